// File: rtl/crc_lfsr_param_pkg.sv
// Shared types and USB CRC presets for the parametrised CRC engine.
package crc_pkg;

  // Engine mode: fold incoming data, or serialise a latched CRC.
  typedef enum logic {
    ACCUM = 1'b0,
    SHIFT = 1'b1
  } crc_state_t;

  // USB CRC16 (data packets)
  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

  // USB CRC5 (token packets)
  localparam logic [4:0]  CRC5_POLY     = 5'h05;
  localparam logic [4:0]  CRC5_RESIDUE  = 5'h0C;

endpackage

// File: rtl/crc_lfsr_param_if.sv
// Data/handshake bundle between the CRC engine and the surrounding
// serial, bit-stuffing and packet logic.
interface crc_lfsr_param_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DATA_W = 1,
  parameter int unsigned CNT_W  = 12
);
  logic              clear;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              start_tx;
  logic              tx_ready;
  logic [WIDTH-1:0]  crc;
  logic              crc_ok;
  logic [CNT_W-1:0]  bit_count;
  logic              tx_bit;
  logic              tx_valid;
  logic              tx_done;
  logic              busy;

  // Side that feeds data and consumes the serial CRC.
  modport master (
    output clear, data_in, data_valid, start_tx, tx_ready,
    input  crc, crc_ok, bit_count, tx_bit, tx_valid, tx_done, busy
  );

  // The CRC engine itself.
  modport slave (
    input  clear, data_in, data_valid, start_tx, tx_ready,
    output crc, crc_ok, bit_count, tx_bit, tx_valid, tx_done, busy
  );
endinterface

// File: rtl/crc_lfsr_param_step.sv
// Combinational LFSR update: folds DATA_W bits into the register,
// bit 0 of d first, MSB-feedback (non-reflected) form.
module crc_lfsr_step #(
  parameter int unsigned      WIDTH  = 16,
  parameter logic [WIDTH-1:0] POLY   = WIDTH'(16'h8005),
  parameter int unsigned      DATA_W = 1
) (
  input  logic [WIDTH-1:0]  q,
  input  logic [DATA_W-1:0] d,
  output logic [WIDTH-1:0]  q_next
);

  logic [WIDTH-1:0] acc;

  // Unrolled per-bit shift with conditional polynomial feedback.
  always_comb begin
    acc = q;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (acc[WIDTH-1] ^ d[i]) begin
        acc = (acc << 1) ^ POLY;
      end else begin
        acc = acc << 1;
      end
    end
    q_next = acc;
  end

endmodule

// File: rtl/crc_lfsr_param.sv
// Parametrised CRC engine: accumulates input bits, exposes the finished
// CRC and a residue check, and serialises the CRC MSB-first on request.
module crc_lfsr_param
  import crc_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter logic [31:0] POLY    = 32'h0000_8005,
  parameter logic [31:0] INIT    = 32'h0000_0000,
  parameter logic [31:0] XOR_OUT = 32'h0000_FFFF,
  parameter logic [31:0] RESIDUE = 32'h0000_800D,
  parameter int unsigned DATA_W  = 1,
  parameter int unsigned CNT_W   = 12
) (
  input logic             clk,
  input logic             n_rst,
  crc_lfsr_param_if.slave bus
);

  localparam logic [WIDTH-1:0] POLY_M    = POLY[WIDTH-1:0];
  localparam logic [WIDTH-1:0] INIT_M    = INIT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] XOR_M     = XOR_OUT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RESIDUE_M = RESIDUE[WIDTH-1:0];
  localparam int unsigned      IDX_W     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WIDTH - 1);

  crc_state_t       state, state_n;
  logic [WIDTH-1:0] q, q_n, q_step;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_sat;
  logic [CNT_W:0]   cnt_sum;
  logic [IDX_W-1:0] idx, idx_n;
  logic             done, done_n;

  crc_lfsr_step #(
    .WIDTH  (WIDTH),
    .POLY   (POLY_M),
    .DATA_W (DATA_W)
  ) u_step (
    .q      (q),
    .d      (bus.data_in),
    .q_next (q_step)
  );

  // Bit counter increment, saturating at all-ones.
  always_comb begin
    cnt_sum = {1'b0, cnt} + (CNT_W + 1)'(DATA_W);
    cnt_sat = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  // Next-state: clear wins over everything; in ACCUM the shift register
  // is loaded from the post-fold value so a same-cycle data beat is
  // included in the transmitted CRC.
  always_comb begin
    state_n = state;
    q_n     = q;
    cnt_n   = cnt;
    shreg_n = shreg;
    idx_n   = idx;
    done_n  = 1'b0;
    if (bus.clear) begin
      state_n = ACCUM;
      q_n     = INIT_M;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (bus.data_valid) begin
            q_n   = q_step;
            cnt_n = cnt_sat;
          end
          if (bus.start_tx) begin
            shreg_n = q_n ^ XOR_M;
            idx_n   = '0;
            state_n = SHIFT;
          end
        end
        SHIFT: begin
          if (bus.tx_ready) begin
            shreg_n = shreg << 1;
            if (idx == LAST_IDX) begin
              idx_n   = '0;
              done_n  = 1'b1;
              state_n = ACCUM;
            end else begin
              idx_n = idx + 1'b1;
            end
          end
        end
        default: state_n = ACCUM;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ACCUM;
      q     <= INIT_M;
      cnt   <= '0;
      shreg <= '0;
      idx   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      q     <= q_n;
      cnt   <= cnt_n;
      shreg <= shreg_n;
      idx   <= idx_n;
      done  <= done_n;
    end
  end

  assign bus.crc       = q ^ XOR_M;
  assign bus.crc_ok    = (q == RESIDUE_M);
  assign bus.bit_count = cnt;
  assign bus.busy      = (state == SHIFT);
  assign bus.tx_valid  = (state == SHIFT);
  assign bus.tx_bit    = (state == SHIFT) & shreg[WIDTH-1];
  assign bus.tx_done   = done;

endmodule

// File: doc/crc_lfsr_param.md
# crc_lfsr_param

Parametrised CRC engine for the USB datapath. It generalises the fixed 16-bit serial CRC generator in width, polynomial, initial value, output inversion and input bits per cycle. It adds receive-side residue checking and a handshaked serial shifter that emits the finished CRC MSB-first to the transmit encoder. It sits between the bit-stuffing/serial layers and the packet FSMs; one instance is used per CRC5 or CRC16 path.

## Interface
- WIDTH, 16: CRC register width (2..32).
- POLY, 16'h8005: generator polynomial, implicit x^WIDTH term omitted.
- INIT, 16'h0000: register value after reset and clear.
- XOR_OUT, 16'hFFFF: mask applied to the register to form `crc`.
- RESIDUE, 16'h800D: register value that indicates a good packet in check mode.
- DATA_W, 1: input bits consumed per valid cycle (1..8).
- CNT_W, 12: width of the bit counter.
- clk  in  1  clock.
- n_rst  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous restart: register←INIT, counter←0, abort shift-out.
- data_in  in  DATA_W  data bits; bit 0 is processed first.
- data_valid  in  1  fold data_in this cycle.
- start_tx  in  1  pulse: latch current CRC and begin serial shift-out.
- tx_ready  in  1  consumer accepts tx_bit this cycle.
- crc  out  WIDTH  Q ^ XOR_OUT, from register.
- crc_ok  out  1  (Q == RESIDUE), from register.
- bit_count  out  CNT_W  bits folded since clear, saturating.
- tx_bit  out  1  current outgoing CRC bit.
- tx_valid  out  1  tx_bit valid.
- tx_done  out  1  one-cycle pulse after the last bit is accepted.
- busy  out  1  high in SHIFT state.

## Operation
- Per-bit step, applied for i = 0..DATA_W-1 in order:
  - t = Q[WIDTH-1] ^ d[i].
  - Q = (Q << 1) ^ (t ? POLY : 0), truncated to WIDTH.
- FSM states:
  - ACCUM: reset state. data_valid folds bits and adds DATA_W to bit_count, saturating at 2^CNT_W-1. start_tx loads shreg ← next_Q ^ XOR_OUT, so same-cycle data is included, and the FSM goes to SHIFT.
  - SHIFT: tx_valid=1, tx_bit=shreg[WIDTH-1]. When tx_valid&tx_ready, shreg shifts left and the index increments. When the last accepted bit has index WIDTH-1, the FSM returns to ACCUM and pulses tx_done. In SHIFT, data_valid and start_tx are ignored and Q is held.
- Priority: clear > start_tx/data_valid. clear in SHIFT returns to ACCUM without a tx_done pulse.
- Check mode is implicit. After the message plus the transmitted CRC (MSB first) have been folded, crc_ok=1 iff no error.
- All parameter-derived constants are masked to WIDTH bits.

## Timing
- Reset values:
  - Q=INIT, so crc=INIT^XOR_OUT (16'hFFFF with defaults).
  - crc_ok=(INIT==RESIDUE).
  - bit_count=0.
  - State ACCUM; tx_valid=0, tx_bit=0, tx_done=0, busy=0.
- crc, crc_ok and bit_count reflect data folded on the previous edge (1-cycle latency).
- start_tx at edge k: tx_valid=1 from cycle k+1.
- With tx_ready held high, shift-out takes WIDTH cycles. tx_done is high in the cycle after the final acceptance, together with busy=0.
- A tx_ready stall holds tx_bit stable.
- Reset asserted mid-shift aborts immediately to the reset values.

## Structure
- Package `crc_pkg`:
  - State enum `crc_state_t {ACCUM, SHIFT}`.
  - USB presets CRC16_POLY=16'h8005, CRC16_RESIDUE=16'h800D, CRC5_POLY=5'h05, CRC5_RESIDUE=5'h0C.
- Sub-module `crc_lfsr_step`: combinational DATA_W-bit unrolled update, parameters WIDTH/POLY/DATA_W.

## Test plan
- Reset with defaults → crc=16'hFFFF, crc_ok=0, bit_count=0, tx_valid=0.
- DATA_W=1: fold bit 1 → crc=16'h7FFA; then fold bit 0 → crc=16'h7FF0, bit_count=2.
- DATA_W=8 versus DATA_W=1: the same 3-byte message gives identical crc. Then feed the complemented CRC MSB-first → crc_ok=1 (Q=16'h800D). Flip one message bit → crc_ok=0.
- Configuration XOR_OUT=0, RESIDUE=0: message followed by its crc → Q=0 and crc_ok=1.
- Shift-out: start_tx after the message, tx_ready toggling 1,0,1… → 16 bits MSB-first match the latched crc. tx_done pulses once; data_valid during SHIFT leaves Q unchanged.
- Boundaries:
  - clear together with data_valid → Q=INIT, bit_count=0.
  - clear at bit 7 of shift-out → busy=0 next cycle, no tx_done.
  - n_rst low mid-shift → reset values.
  - bit_count saturates at 4095.
